// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debouncer and press/hold/repeat event generator
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 15_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold,
    output logic [NUM_BTN-1:0] btn_repeat
);

    // Debounce counter only ever reaches DEBOUNCE_CYCLES-1 before it is cleared.
    localparam int DEB_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // One counter serves both the hold and the repeat interval, so size it for the larger one.
    localparam int HLD_LIMIT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HLD_W     = (HLD_LIMIT < 1) ? 1 : $clog2(HLD_LIMIT + 1);
    localparam logic [HLD_W-1:0] HOLD_LAST   = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [HLD_W-1:0] REPEAT_LAST = HLD_W'(REPEAT_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_MAX     = {HLD_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_bit;
        logic [DEB_W-1:0]       deb_cnt;
        logic                   level_q;
        logic                   settle;
        logic                   rise_now;
        logic                   fall_now;
        logic                   press_q;
        logic                   release_q;

        state_t                 state_q;
        state_t                 state_d;
        logic [HLD_W-1:0]       hold_cnt_q;
        logic [HLD_W-1:0]       hold_cnt_d;
        logic [HLD_W-1:0]       hold_cnt_inc;
        logic                   hold_d;
        logic                   repeat_d;
        logic                   hold_q;
        logic                   repeat_q;

        // Metastability chain: the raw pin enters at bit 0, the settled value leaves at the top bit.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
            end
        end

        assign sync_bit = sync_q[SYNC_STAGES-1];

        // The level flips on the edge where a mismatch has survived DEBOUNCE_CYCLES consecutive cycles.
        assign settle   = (sync_bit != level_q) && (deb_cnt == DEB_LAST);
        assign rise_now = settle &  sync_bit;
        assign fall_now = settle & ~sync_bit;

        // Debounce counter and debounced level; any return to the current level restarts the count.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                deb_cnt <= '0;
                level_q <= 1'b0;
            end else if (sync_bit == level_q) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                level_q <= sync_bit;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end

        // Edge pulses are registered alongside the level so they appear in its first new cycle.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rise_now;
                release_q <= fall_now;
            end
        end

        assign hold_cnt_inc = (hold_cnt_q == HLD_MAX) ? hold_cnt_q : hold_cnt_q + HLD_W'(1);

        // Hold/repeat sequencing; a release on the same edge wins over a pending hold or repeat.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_inc;
            hold_d     = 1'b0;
            repeat_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hold_cnt_d = '0;
                    if (rise_now) begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (fall_now) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_HELD;
                        hold_cnt_d = '0;
                        hold_d     = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (fall_now) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == REPEAT_LAST) begin
                        hold_cnt_d = '0;
                        repeat_d   = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end

        // State, interval counter and registered hold/repeat pulses.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q    <= ST_IDLE;
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
                repeat_q   <= 1'b0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                hold_q     <= hold_d;
                repeat_q   <= repeat_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_hold[i]    = hold_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
`timescale 1ns/1ps
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic [4:0] btn_hold;
    logic [4:0] btn_repeat;

    int vectors = 0;
    int errors  = 0;

    button_conditioner #(
        .NUM_BTN        (5),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold),
        .btn_repeat (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Vector order everywhere: {level, press, release, hold, repeat}.

    task automatic test_reset();
        reset   = 1'b0;
        btn_raw = 5'b11111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== 25'h0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, 25'h0);
            end
        end
        btn_raw = 5'b00000;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== 25'h0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, 25'h0);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] el, ep, er, eh, et;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            el = '0; ep = '0; er = '0; eh = '0; et = '0;
            el[1] = (k >= 6 && k < 18);
            ep[1] = (k == 6);
            er[1] = (k == 18);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== {el, ep, er, eh, et}) begin
                errors++;
                $display("FAIL clean_press k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, {el, ep, er, eh, et});
            end
            btn_raw    = '0;
            btn_raw[1] = (k < 12);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] el, ep, er, eh, et;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            el = '0; ep = '0; er = '0; eh = '0; et = '0;
            el[3] = (k >= 18 && k < 30);
            ep[3] = (k == 18);
            er[3] = (k == 30);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== {el, ep, er, eh, et}) begin
                errors++;
                $display("FAIL bounce k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, {el, ep, er, eh, et});
            end
            btn_raw = '0;
            if (k < 12) btn_raw[3] = (((k / 2) % 2) == 0);
            else        btn_raw[3] = (k < 24);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== 25'h0) begin
                errors++;
                $display("FAIL glitch k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, 25'h0);
            end
            btn_raw    = '0;
            btn_raw[0] = (k < 3);
        end
    endtask

    task automatic test_long_press();
        logic [4:0] el, ep, er, eh, et;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            el = '0; ep = '0; er = '0; eh = '0; et = '0;
            el[3] = (k >= 6 && k < 66);
            ep[3] = (k == 6);
            eh[3] = (k == 26);
            et[3] = (k == 34 || k == 42 || k == 50 || k == 58);
            er[3] = (k == 66);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== {el, ep, er, eh, et}) begin
                errors++;
                $display("FAIL long_press k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, {el, ep, er, eh, et});
            end
            btn_raw    = '0;
            btn_raw[3] = (k < 60);
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] el, ep, er, eh, et;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            el = '0; ep = '0; er = '0; eh = '0; et = '0;
            el[1] = (k >= 6 && k < 16);
            el[2] = (k >= 6 && k < 46);
            ep[1] = (k == 6);
            ep[2] = (k == 6);
            er[1] = (k == 16);
            er[2] = (k == 46);
            eh[2] = (k == 26);
            et[2] = (k == 34 || k == 42);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== {el, ep, er, eh, et}) begin
                errors++;
                $display("FAIL simultaneous k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, {el, ep, er, eh, et});
            end
            btn_raw    = '0;
            btn_raw[1] = (k < 10);
            btn_raw[2] = (k < 40);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] el, ep, er, eh, et;
        // Press and hold until hold_cnt has reached 10 (ten cycles after the press pulse).
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            el = '0; ep = '0; er = '0; eh = '0; et = '0;
            el[4] = (k >= 6);
            ep[4] = (k == 6);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== {el, ep, er, eh, et}) begin
                errors++;
                $display("FAIL pre_reset k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, {el, ep, er, eh, et});
            end
            btn_raw = 5'b10000;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== 25'h0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h",
                     {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, 25'h0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== 25'h0) begin
                errors++;
                $display("FAIL in_reset k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, 25'h0);
            end
        end
        // Button still down when reset lifts: behaves as a fresh press, no release for the old one.
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            el = '0; ep = '0; er = '0; eh = '0; et = '0;
            el[4] = (k >= 6 && k < 36);
            ep[4] = (k == 6);
            eh[4] = (k == 26);
            et[4] = (k == 34);
            er[4] = (k == 36);
            vectors++;
            if ({btn_level, btn_press, btn_release, btn_hold, btn_repeat} !== {el, ep, er, eh, et}) begin
                errors++;
                $display("FAIL post_reset k=%0d got=%h want=%h", k,
                         {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, {el, ep, er, eh, et});
            end
            if (k == 0) reset = 1'b1;
            btn_raw    = '0;
            btn_raw[4] = (k < 30);
        end
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_simultaneous();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
